// File: rtl/snake_pkg.sv
// snake_pkg: shared defaults and synchronizer depth bounds for the tick receiver
package snake_pkg;
    localparam int PERIOD_W_DEF = 24;
    localparam logic [23:0] LOST_LIMIT_DEF = 24'd5_000_000;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
endpackage

// File: rtl/tick_edge_rx.sv
// tick_edge_rx: multi-flop synchronizer, prev register and enable-gated rising-edge strobe
module tick_edge_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic enable,
    output logic level,
    output logic tick
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign level = sync[SYNC_STAGES-1];
    assign tick  = enable & level & ~prev;
endmodule

// File: rtl/snake_tick_rx.sv
// snake_tick_rx: divider clock receiver with tick strobes, fast period measurement and
// optional stall watchdog (enabled by defining SNAKE_TICK_WATCHDOG_EN)
module snake_tick_rx
    import snake_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          PERIOD_W    = PERIOD_W_DEF,
    parameter logic [23:0] LOST_LIMIT  = LOST_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fast_clk_in,
    input  logic                blink_clk_in,
    output logic                fast_tick,
    output logic                blink_tick,
    output logic                blink_level,
    output logic [PERIOD_W-1:0] fast_period,
    output logic                period_valid,
    output logic                fast_lost
);
    localparam int S = SYNC_STAGES < SYNC_MIN ? SYNC_MIN : SYNC_STAGES > SYNC_MAX ? SYNC_MAX : SYNC_STAGES;
    localparam logic [2:0] WARM_END = 3'(S + 1);
    logic [2:0] warm;
    logic warm_done;
    logic fast_level_unused;
    logic [PERIOD_W-1:0] cnt;
    logic seen;
    assign warm_done = (warm == WARM_END);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) warm <= '0;
        else if (!warm_done) warm <= warm + 3'd1;
    end
    tick_edge_rx #(.SYNC_STAGES(S)) u_fast (
        .clk(clk), .rst(rst), .async_in(fast_clk_in), .enable(warm_done),
        .level(fast_level_unused), .tick(fast_tick)
    );
    tick_edge_rx #(.SYNC_STAGES(S)) u_blink (
        .clk(clk), .rst(rst), .async_in(blink_clk_in), .enable(warm_done),
        .level(blink_level), .tick(blink_tick)
    );
    // first tick only arms the measurement; later ticks publish cnt+1, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            fast_period  <= '0;
            period_valid <= 1'b0;
            seen         <= 1'b0;
        end else if (fast_tick) begin
            cnt  <= '0;
            seen <= 1'b1;
            if (seen) begin
                fast_period  <= &cnt ? cnt : cnt + 1'b1;
                period_valid <= 1'b1;
            end
        end else if (!(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end
`ifdef SNAKE_TICK_WATCHDOG_EN
    localparam int unsigned LIM = 32'(LOST_LIMIT);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fast_lost <= 1'b0;
        else if (fast_tick) fast_lost <= 1'b0;
        else if (warm_done && 32'(cnt) >= LIM) fast_lost <= 1'b1;
    end
`else
    assign fast_lost = 1'b0;
`endif
endmodule
